// File: rtl/sysid_timer_regs.sv
// System-identification slave: fixed ID/timestamp/info words, prescaled uptime counter with a
// coherent LO/HI snapshot, and byte-writable scratch registers on an Avalon-MM read/write port.
module sysid_timer_regs #(
  parameter logic [31:0] SYS_ID      = 32'h4E4D_FF79,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int unsigned PRESCALE    = 50,
  parameter int unsigned CNT_WIDTH   = 48,
  parameter int unsigned NUM_SCRATCH = 2,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned HW = CNT_WIDTH - 32;
  localparam logic [PW-1:0] PLast = PW'(PRESCALE - 1);

  localparam logic [ADDR_W-1:0] AddrId   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrTs   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrInfo = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrCtrl = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrLo   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AddrHi   = ADDR_W'(5);

  localparam logic [31:0] InfoWord = {16'h0001, 8'(CNT_WIDTH), 8'(NUM_SCRATCH)};

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [HW-1:0]        hi_q, hi_d;
  logic                 run_q, run_d;
  logic                 wrapped_q, wrapped_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          scratch_q [NUM_SCRATCH];
  logic [31:0]          scratch_d [NUM_SCRATCH];

  logic wr_en, ctrl_wr, clr, tick, wrap_set;

  always_comb begin
    // A read in the same cycle as a write takes the port; the write is dropped.
    wr_en    = write & ~read;
    ctrl_wr  = wr_en && (address == AddrCtrl);
    clr      = ctrl_wr & writedata[1];
    tick     = run_q && (pcnt_q == PLast);
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    wrap_set = 1'b0;

    if (clr) begin
      cnt_d  = '0;
      pcnt_d = '0;
    end else if (run_q) begin
      if (tick) begin
        pcnt_d   = '0;
        cnt_d    = cnt_q + 1'b1;
        wrap_set = &cnt_q;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    run_d     = ctrl_wr ? writedata[0] : run_q;
    wrapped_d = wrap_set | (wrapped_q & ~(ctrl_wr & writedata[2]));
  end

  always_comb begin
    hi_d     = hi_q;
    rvalid_d = read;
    rdata_d  = rdata_q;
    if (read) begin
      rdata_d = '0;
      case (address)
        AddrId:   rdata_d = SYS_ID;
        AddrTs:   rdata_d = TIMESTAMP;
        AddrInfo: rdata_d = InfoWord;
        AddrCtrl: rdata_d = {29'b0, wrapped_q, 1'b0, run_q};
        AddrLo: begin
          // Snapshot the upper bits alongside LO so a later HI read is coherent.
          rdata_d = cnt_q[31:0];
          hi_d    = cnt_q[CNT_WIDTH-1:32];
        end
        AddrHi:   rdata_d = 32'(hi_q);
        default: begin
          for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
            if (address == ADDR_W'(6 + i)) rdata_d = scratch_q[i];
          end
        end
      endcase
    end
  end

  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_en && (address == ADDR_W'(6 + i)) && byteenable[b]) begin
          scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      pcnt_q    <= '0;
      hi_q      <= '0;
      run_q     <= 1'b1;
      wrapped_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      scratch_q <= '{default: '0};
    end else begin
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      hi_q      <= hi_d;
      run_q     <= run_d;
      wrapped_q <= wrapped_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      scratch_q <= scratch_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_timer_regs.sv
// Bench for sysid_timer_regs: directed vector table, hand sequences for counter corners and a
// randomized run checked against a cycle-level arithmetic reference model.
module tb_sysid_timer_regs;

  localparam int P = 4;
  localparam longint unsigned CMAX = (64'd1 << 48) - 64'd1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sysid_timer_regs #(
    .PRESCALE   (P),
    .CNT_WIDTH  (48),
    .NUM_SCRATCH(2),
    .ADDR_W     (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  // Reference model state
  longint unsigned m_cnt;
  int              m_pcnt;
  bit              m_run, m_wrap, m_rv;
  logic [15:0]     m_hi;
  logic [31:0]     m_scr [2];
  logic [31:0]     m_rdata;

  logic [47:0] f_cnt;
  logic [1:0]  f_pcnt;

  typedef struct {
    bit          rd;
    bit          wr;
    int          addr;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0: return 32'h4E4D_FF79;
      1: return 32'h0;
      2: return 32'h0001_3002;
      3: return {29'b0, m_wrap, 1'b0, m_run};
      4: return m_cnt[31:0];
      5: return {16'b0, m_hi};
      6, 7: return m_scr[a-6];
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step(input bit rst, input bit rd, input bit wr, input int a,
                            input logic [31:0] wd, input logic [3:0] be);
    bit wok, ctl, ws;
    if (rst) begin
      m_cnt = 0; m_pcnt = 0; m_hi = '0; m_run = 1; m_wrap = 0;
      m_scr[0] = '0; m_scr[1] = '0; m_rdata = '0; m_rv = 0;
      return;
    end
    m_rv = rd;
    if (rd) begin
      m_rdata = m_read(a);
      if (a == 4) m_hi = m_cnt[47:32];
    end
    wok = wr && !rd;
    ctl = wok && (a == 3);
    ws  = 0;
    if (ctl && wd[1]) begin
      m_cnt = 0; m_pcnt = 0;
    end else if (m_run) begin
      m_pcnt++;
      if (m_pcnt == P) begin
        m_pcnt = 0;
        ws = (m_cnt == CMAX);
        m_cnt = (m_cnt + 1) % (CMAX + 1);
      end
    end
    if (ws) m_wrap = 1;
    else if (ctl && wd[2]) m_wrap = 0;
    if (ctl) m_run = wd[0];
    if (wok && (a == 6 || a == 7)) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_scr[a-6][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic cycle(input bit rst, input bit rd, input bit wr, input int a,
                       input logic [31:0] wd, input logic [3:0] be);
    reset = rst; read = rd; write = wr; address = a[3:0]; writedata = wd; byteenable = be;
    model_step(rst, rd, wr, a, wd, be);
    @(posedge clock);
    #1;
    check("readdatavalid", 64'(readdatavalid), 64'(m_rv));
    check("readdata", 64'(readdata), 64'(m_rdata));
    reset = 0; read = 0; write = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 4'h0);
  endtask

  task automatic rd_reg(input int a);
    cycle(0, 1, 0, a, 32'h0, 4'h0);
  endtask

  task automatic wr_reg(input int a, input logic [31:0] wd);
    cycle(0, 0, 1, a, wd, 4'hF);
  endtask

  // Place the counter mid-cycle; the next clock edge sees these values.
  task automatic preload(input longint unsigned c, input int p);
    f_cnt  = c[47:0];
    f_pcnt = p[1:0];
    force dut.cnt_q = f_cnt;
    force dut.pcnt_q = f_pcnt;
    #1;
    release dut.cnt_q;
    release dut.pcnt_q;
    m_cnt  = c;
    m_pcnt = p;
  endtask

  logic [31:0] v1;
  bit r_rd, r_wr;
  int r_a;
  logic [31:0] r_wd;

  initial begin
    vecs[0]  = '{1, 0, 0, 32'h0, 4'h0, 1, 32'h4E4D_FF79};
    vecs[1]  = '{1, 0, 1, 32'h0, 4'h0, 1, 32'h0000_0000};
    vecs[2]  = '{1, 0, 2, 32'h0, 4'h0, 1, 32'h0001_3002};
    vecs[3]  = '{1, 0, 3, 32'h0, 4'h0, 1, 32'h0000_0001};
    vecs[4]  = '{1, 0, 6, 32'h0, 4'h0, 1, 32'h0000_0000};
    vecs[5]  = '{0, 1, 6, 32'hDEAD_BEEF, 4'b0101, 0, 32'h0};
    vecs[6]  = '{1, 0, 6, 32'h0, 4'h0, 1, 32'h00AD_00EF};
    vecs[7]  = '{1, 1, 6, 32'h1234_5678, 4'hF, 1, 32'h00AD_00EF};
    vecs[8]  = '{1, 0, 6, 32'h0, 4'h0, 1, 32'h00AD_00EF};
    vecs[9]  = '{0, 1, 7, 32'hCAFE_F00D, 4'hF, 0, 32'h0};
    vecs[10] = '{1, 0, 7, 32'h0, 4'h0, 1, 32'hCAFE_F00D};
    vecs[11] = '{0, 1, 15, 32'hFFFF_FFFF, 4'hF, 0, 32'h0};
    vecs[12] = '{1, 0, 15, 32'h0, 4'h0, 1, 32'h0000_0000};
    vecs[13] = '{0, 0, 0, 32'h0, 4'h0, 1, 32'h0000_0000};
    vecs[14] = '{1, 0, 5, 32'h0, 4'h0, 1, 32'h0000_0000};

    cycle(1, 0, 0, 0, 32'h0, 4'h0);
    cycle(1, 0, 0, 0, 32'h0, 4'h0);
    check("reset_rdata", 64'(readdata), 64'h0);
    check("reset_rvalid", 64'(readdatavalid), 64'h0);

    for (int i = 0; i < 15; i++) begin
      cycle(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_data", i), 64'(readdata), 64'(vecs[i].exp));
        check($sformatf("vec%0d_valid", i), 64'(readdatavalid), 64'(vecs[i].rd));
      end
    end

    // Uptime with PRESCALE=4: clear, 40 clocks, read LO/HI; then stop and confirm it holds.
    wr_reg(3, 32'h3);
    idle(40);
    rd_reg(4);
    check("uptime_lo_40", 64'(readdata >= 9 && readdata <= 11), 64'h1);
    rd_reg(5);
    check("uptime_hi_40", 64'(readdata), 64'h0);
    wr_reg(3, 32'h0);
    rd_reg(4);
    v1 = readdata;
    idle(20);
    rd_reg(4);
    check("uptime_frozen", 64'(readdata), 64'(v1));
    wr_reg(3, 32'h1);

    // LO read on the tick that carries into bit 32.
    preload(64'h0000_FFFF_FFFF, 3);
    rd_reg(4);
    check("carry_lo_pre", 64'(readdata), 64'hFFFF_FFFF);
    rd_reg(5);
    check("carry_hi_pre", 64'(readdata), 64'h0);
    rd_reg(4);
    check("carry_lo_post", 64'(readdata), 64'h0);
    rd_reg(5);
    check("carry_hi_post", 64'(readdata), 64'h1);

    // Wrap, sticky flag, W1C, set-beats-clear, and CLEAR beating a tick.
    preload(CMAX, 3);
    idle(1);
    rd_reg(3);
    check("wrap_ctrl", 64'(readdata), 64'h5);
    rd_reg(4);
    check("wrap_lo", 64'(readdata), 64'h0);
    wr_reg(3, 32'h5);
    rd_reg(3);
    check("w1c_ctrl", 64'(readdata), 64'h1);
    preload(CMAX, 3);
    wr_reg(3, 32'h5);
    rd_reg(3);
    check("set_wins_ctrl", 64'(readdata), 64'h5);
    wr_reg(3, 32'h5);
    preload(64'd100, 3);
    wr_reg(3, 32'h3);
    rd_reg(4);
    check("clear_on_tick", 64'(readdata), 64'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 0) preload(CMAX - 64'($urandom_range(0, 2)), $urandom_range(0, 3));
      r_rd = ($urandom % 2) == 0;
      r_wr = ($urandom % 3) == 0;
      r_a  = $urandom % 16;
      r_wd = $urandom;
      if (r_a == 3) r_wd[0] = ($urandom % 4) != 0;
      cycle(($urandom % 100) == 0, r_rd, r_wr, r_a, r_wd, 4'($urandom));
    end

    // Reset while a read is in flight and with a read in the reset cycle.
    wr_reg(6, 32'h1111_2222);
    wr_reg(3, 32'h0);
    rd_reg(0);
    check("pre_reset_valid", 64'(readdatavalid), 64'h1);
    cycle(1, 1, 0, 0, 32'h0, 4'h0);
    check("reset_read_dropped", 64'(readdatavalid), 64'h0);
    check("reset_read_data", 64'(readdata), 64'h0);
    rd_reg(3);
    check("reset_ctrl", 64'(readdata), 64'h1);
    rd_reg(6);
    check("reset_scratch0", 64'(readdata), 64'h0);
    rd_reg(5);
    check("reset_hi_shadow", 64'(readdata), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
